// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: pattern word stream in, lock status and error counters out.
interface lfsr_checker_if #(
    parameter int WERR_W = 16,
    parameter int BERR_W = 24
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              clear_cnt;
    logic              locked;
    logic              err_pulse;
    logic [WERR_W-1:0] word_err_cnt;
    logic [BERR_W-1:0] bit_err_cnt;

    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, err_pulse, word_err_cnt, bit_err_cnt
    );

    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, err_pulse, word_err_cnt, bit_err_cnt
    );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising 32-bit LFSR pattern checker with lock tracking.
module lfsr_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int WERR_W       = 16,
    parameter int BERR_W       = 24
) (
    input logic           clk,
    input logic           reset_n,
    lfsr_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state;
    logic [31:0] pred;
    logic [MW-1:0] match_cnt;
    logic [UW-1:0] miss_cnt;
    logic [31:0] diff;
    logic [5:0]  pc;
    logic [BERR_W:0] bsum;
    logic        mism;

    function automatic logic [31:0] f(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[0]};
    endfunction

    always_comb begin
        diff = bus.in_data ^ pred;
        mism = |diff;
        pc = '0;
        for (int i = 0; i < 32; i++) pc = pc + 6'(diff[i]);
        bsum = {1'b0, bus.bit_err_cnt} + (BERR_W + 1)'(pc);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= SEARCH;
            pred             <= '0;
            match_cnt        <= '0;
            miss_cnt         <= '0;
            bus.locked       <= 1'b0;
            bus.err_pulse    <= 1'b0;
            bus.word_err_cnt <= '0;
            bus.bit_err_cnt  <= '0;
        end else begin
            bus.err_pulse <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    SEARCH: if (|bus.in_data) begin
                        pred      <= f(bus.in_data);
                        match_cnt <= '0;
                        state     <= VERIFY;
                    end
                    VERIFY: if (!mism) begin
                        pred      <= f(pred);
                        match_cnt <= match_cnt + MW'(1);
                        if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                            miss_cnt   <= '0;
                        end
                    end else if (|bus.in_data) begin
                        pred      <= f(bus.in_data);
                        match_cnt <= '0;
                    end else begin
                        state <= SEARCH;
                    end
                    LOCKED: begin
                        // prediction free-runs so a corrupted word never poisons later checks
                        pred <= f(pred);
                        if (!mism) begin
                            miss_cnt <= '0;
                        end else begin
                            bus.err_pulse <= 1'b1;
                            miss_cnt      <= miss_cnt + UW'(1);
                            if (bus.word_err_cnt != '1) bus.word_err_cnt <= bus.word_err_cnt + WERR_W'(1);
                            bus.bit_err_cnt <= bsum[BERR_W] ? '1 : bsum[BERR_W-1:0];
                            if (miss_cnt == UW'(UNLOCK_COUNT - 1)) begin
                                state      <= SEARCH;
                                bus.locked <= 1'b0;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            if (bus.clear_cnt) begin
                bus.word_err_cnt <= '0;
                bus.bit_err_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed lock, error, unlock, reseed, saturation and async reset checks.
module tb_lfsr_checker;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int nvec = 0;
    int nerr = 0;
    logic [31:0] cur;

    lfsr_checker_if #(.WERR_W(4), .BERR_W(24)) bus ();

    lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .WERR_W(4), .BERR_W(24)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic c);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.clear_cnt = c;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.clear_cnt = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.clear_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_err", 32'(bus.err_pulse), 0);
        chk("rst_wcnt", 32'(bus.word_err_cnt), 0);
        chk("rst_bcnt", 32'(bus.bit_err_cnt), 0);
        reset_n = 1'b1;

        step(1, 32'h0000ACE1, 0);
        chk("seed_locked", 32'(bus.locked), 0);
        step(1, 32'h000159C3, 0);
        step(1, 32'h0002B387, 0);
        step(1, 32'h0005670F, 0);
        chk("pre_lock", 32'(bus.locked), 0);
        step(1, 32'h000ACE1F, 0);
        chk("lock", 32'(bus.locked), 1);
        chk("lock_err", 32'(bus.err_pulse), 0);
        chk("lock_wcnt", 32'(bus.word_err_cnt), 0);

        step(1, 32'h00159C3A, 0);
        chk("err_pulse", 32'(bus.err_pulse), 1);
        chk("err_wcnt", 32'(bus.word_err_cnt), 1);
        chk("err_bcnt", 32'(bus.bit_err_cnt), 2);
        chk("err_locked", 32'(bus.locked), 1);
        step(1, 32'h002B387F, 0);
        chk("recover_err", 32'(bus.err_pulse), 0);
        chk("recover_wcnt", 32'(bus.word_err_cnt), 1);
        cur = 32'h005670FF;

        for (int i = 0; i < 10; i++) step(0, 32'hDEAD0000 + i, 0);
        chk("gap_locked", 32'(bus.locked), 1);
        chk("gap_wcnt", 32'(bus.word_err_cnt), 1);
        step(1, cur, 0);
        cur = f(cur);
        chk("post_gap_err", 32'(bus.err_pulse), 0);
        chk("post_gap_wcnt", 32'(bus.word_err_cnt), 1);

        step(0, 0, 1);
        chk("clear_wcnt", 32'(bus.word_err_cnt), 0);
        chk("clear_locked", 32'(bus.locked), 1);
        step(1, cur ^ 32'h1, 0);
        cur = f(cur);
        step(1, cur ^ 32'h1, 0);
        cur = f(cur);
        chk("miss2_locked", 32'(bus.locked), 1);
        step(1, cur ^ 32'h1, 0);
        chk("unlock", 32'(bus.locked), 0);
        chk("unlock_wcnt", 32'(bus.word_err_cnt), 3);
        chk("unlock_bcnt", 32'(bus.bit_err_cnt), 3);
        step(1, 32'h0, 0);
        chk("zero_search", 32'(bus.locked), 0);

        cur = 32'h1;
        step(1, cur, 0);
        cur = f(cur);
        step(1, cur, 0);
        for (int i = 0; i < 10; i++) step(0, 32'h0, 0);
        cur = 32'h80000000;
        step(1, cur, 0);
        cur = f(cur);
        for (int i = 0; i < 3; i++) begin
            step(1, cur, 0);
            cur = f(cur);
        end
        chk("reseed_not_yet", 32'(bus.locked), 0);
        step(1, cur, 0);
        cur = f(cur);
        chk("reseed_lock", 32'(bus.locked), 1);
        chk("verify_no_count", 32'(bus.word_err_cnt), 3);

        for (int i = 0; i < 20; i++) begin
            step(1, cur ^ 32'h8, 0);
            cur = f(cur);
            step(1, cur, 0);
            cur = f(cur);
        end
        chk("sat_wcnt", 32'(bus.word_err_cnt), 32'hF);
        chk("sat_bcnt", 32'(bus.bit_err_cnt), 23);
        chk("sat_locked", 32'(bus.locked), 1);

        step(1, cur ^ 32'hFF, 1);
        cur = f(cur);
        chk("clr_err_pulse", 32'(bus.err_pulse), 1);
        chk("clr_err_wcnt", 32'(bus.word_err_cnt), 0);
        chk("clr_err_bcnt", 32'(bus.bit_err_cnt), 0);
        step(1, cur ^ 32'h3, 0);
        cur = f(cur);
        chk("after_clr_wcnt", 32'(bus.word_err_cnt), 1);
        chk("after_clr_bcnt", 32'(bus.bit_err_cnt), 2);
        step(1, cur, 0);
        cur = f(cur);
        chk("pre_arst_locked", 32'(bus.locked), 1);

        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_locked", 32'(bus.locked), 0);
        chk("arst_wcnt", 32'(bus.word_err_cnt), 0);
        chk("arst_bcnt", 32'(bus.bit_err_cnt), 0);
        #3;
        reset_n = 1'b1;
        step(1, cur, 0);
        chk("arst_search", 32'(bus.locked), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
